// File: rtl/control_unit.sv
// control_unit: registered RV32IM main decoder at the ID/EX boundary.
// Ports: CLK rising-edge clock; RESET asynchronous active-low; FLUSH loads a NOP at the edge;
//   INSTRUCTION word from IF/ID; MUX1 (A: rs1/PC), MUX2 (B: rs2/imm), MUX3 (WB: ALU/mem);
//   REGISTERWRITE, MEMORYWRITE, MEMORYREAD enables; BRANCH, JUMP, JAL control flow;
//   TWOSCOMP negates operand B; ALUOP operation code; IMMEDIATE format (I,S,B,U,J).
// Define CU_ILLEGAL_DETECT_EN to add ILLEGAL, flagging unknown opcodes and bad R-type encodings.
module control_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] INSTRUCTION,
  output logic        MUX1,
  output logic        MUX2,
  output logic        MUX3,
  output logic        REGISTERWRITE,
  output logic        MEMORYWRITE,
  output logic        MEMORYREAD,
  output logic        BRANCH,
  output logic        JUMP,
  output logic        JAL,
  output logic        TWOSCOMP,
  output logic [4:0]  ALUOP,
  output logic [2:0]  IMMEDIATE
`ifdef CU_ILLEGAL_DETECT_EN
  ,
  output logic        ILLEGAL
`endif
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_FWD  = 5'b01111;
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        mux1_d, mux2_d, mux3_d, rw_d, mw_d, mr_d, br_d, jmp_d, jal_d, tc_d;
  logic [4:0]  aluop_d;
  logic [2:0]  imm_d;
  logic [17:0] dec, ctl_d, ctl_q;
  logic        unused_fields;
  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];
  assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};
  always_comb begin
    mux1_d  = 1'b0;
    mux2_d  = 1'b0;
    mux3_d  = 1'b0;
    rw_d    = 1'b0;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    br_d    = 1'b0;
    jmp_d   = 1'b0;
    jal_d   = 1'b0;
    tc_d    = 1'b0;
    aluop_d = ALU_ADD;
    imm_d   = IMM_I;
    case (opcode)
      OP_R: begin
        rw_d = 1'b1;
        if (funct7 == 7'b0000000) aluop_d = {2'b00, funct3};
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) tc_d = 1'b1;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) aluop_d = ALU_SRA;
        else if (funct7 == 7'b0000001) aluop_d = {2'b10, funct3};
        else rw_d = 1'b0;
      end
      OP_I: begin
        rw_d    = 1'b1;
        mux2_d  = 1'b1;
        aluop_d = (funct3 == 3'b101 && funct7 == 7'b0100000) ? ALU_SRA : {2'b00, funct3};
      end
      OP_LOAD: begin
        rw_d   = 1'b1;
        mr_d   = 1'b1;
        mux3_d = 1'b1;
        mux2_d = 1'b1;
      end
      OP_STORE: begin
        mw_d   = 1'b1;
        mux2_d = 1'b1;
        imm_d  = IMM_S;
      end
      OP_BR: begin
        br_d    = 1'b1;
        tc_d    = 1'b1;
        imm_d   = IMM_B;
        aluop_d = {2'b11, funct3};
      end
      OP_JAL: begin
        jmp_d  = 1'b1;
        jal_d  = 1'b1;
        rw_d   = 1'b1;
        mux1_d = 1'b1;
        mux2_d = 1'b1;
        imm_d  = IMM_J;
      end
      OP_JALR: begin
        jmp_d  = 1'b1;
        rw_d   = 1'b1;
        mux2_d = 1'b1;
      end
      OP_LUI: begin
        rw_d    = 1'b1;
        mux2_d  = 1'b1;
        imm_d   = IMM_U;
        aluop_d = ALU_FWD;
      end
      OP_AUIPC: begin
        rw_d   = 1'b1;
        mux1_d = 1'b1;
        mux2_d = 1'b1;
        imm_d  = IMM_U;
      end
      default: ;
    endcase
    dec   = {mux1_d, mux2_d, mux3_d, rw_d, mw_d, mr_d, br_d, jmp_d, jal_d, tc_d, aluop_d, imm_d};
    ctl_d = FLUSH ? '0 : dec;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ctl_q <= '0;
    else ctl_q <= ctl_d;
  assign {MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL, TWOSCOMP,
          ALUOP, IMMEDIATE} = ctl_q;
`ifdef CU_ILLEGAL_DETECT_EN
  // Every legal encoding sets at least one enable, so an all-zero decode marks an illegal word.
  logic ill_d, ill_q;
  always_comb ill_d = ~FLUSH & ~|dec;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ill_q <= 1'b0;
    else ill_q <= ill_d;
  assign ILLEGAL = ill_q;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and random checks of control_unit against a mnemonic-level model.
module tb_control_unit;
  logic        CLK = 1'b0, RESET = 1'b0, FLUSH = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL, TWOSCOMP;
  logic [4:0]  ALUOP;
  logic [2:0]  IMMEDIATE;
  logic        ILLEGAL;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  control_unit dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .INSTRUCTION(INSTRUCTION),
    .MUX1(MUX1), .MUX2(MUX2), .MUX3(MUX3), .REGISTERWRITE(REGISTERWRITE),
    .MEMORYWRITE(MEMORYWRITE), .MEMORYREAD(MEMORYREAD), .BRANCH(BRANCH), .JUMP(JUMP),
    .JAL(JAL), .TWOSCOMP(TWOSCOMP), .ALUOP(ALUOP), .IMMEDIATE(IMMEDIATE)
`ifdef CU_ILLEGAL_DETECT_EN
    , .ILLEGAL(ILLEGAL)
`endif
  );
`ifndef CU_ILLEGAL_DETECT_EN
  assign ILLEGAL = 1'b0;
`endif
  function automatic logic [18:0] obs();
    return {MUX1, MUX2, MUX3, REGISTERWRITE, MEMORYWRITE, MEMORYREAD, BRANCH, JUMP, JAL, TWOSCOMP,
            ALUOP, IMMEDIATE, ILLEGAL};
  endfunction
  function automatic logic [18:0] model(input logic [31:0] ins);
    logic m1 = 0, m2 = 0, m3 = 0, rw = 0, mw = 0, mr = 0, br = 0, j = 0, jl = 0, tc = 0, ill = 0;
    logic [4:0] op = 0;
    logic [2:0] im = 0;
    int opc = int'(ins[6:0]), f3 = int'(ins[14:12]), f7 = int'(ins[31:25]);
    if (opc == 'h33) begin
      if (f7 == 0) begin rw = 1; op = 5'(f3); end
      else if (f7 == 'h20 && f3 == 0) begin rw = 1; tc = 1; end
      else if (f7 == 'h20 && f3 == 5) begin rw = 1; op = 13; end
      else if (f7 == 1) begin rw = 1; op = 5'(16 + f3); end
      else ill = 1;
    end
    else if (opc == 'h13) begin rw = 1; m2 = 1; op = (f3 == 5 && f7 == 'h20) ? 5'd13 : 5'(f3); end
    else if (opc == 'h03) begin rw = 1; mr = 1; m3 = 1; m2 = 1; end
    else if (opc == 'h23) begin mw = 1; m2 = 1; im = 1; end
    else if (opc == 'h63) begin br = 1; tc = 1; im = 2; op = 5'(24 + f3); end
    else if (opc == 'h6F) begin j = 1; jl = 1; rw = 1; m1 = 1; m2 = 1; im = 4; end
    else if (opc == 'h67) begin j = 1; rw = 1; m2 = 1; end
    else if (opc == 'h37) begin rw = 1; m2 = 1; im = 3; op = 15; end
    else if (opc == 'h17) begin rw = 1; m1 = 1; m2 = 1; im = 3; end
    else ill = 1;
`ifndef CU_ILLEGAL_DETECT_EN
    ill = 0;
`endif
    return {m1, m2, m3, rw, mw, mr, br, j, jl, tc, op, im, ill};
  endfunction
  function automatic logic [18:0] expect_of(input logic [31:0] ins, input logic fl);
    return fl ? 19'h0 : model(ins);
  endfunction
  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic step(input string tag, input logic [31:0] ins, input logic fl);
    @(negedge CLK);
    INSTRUCTION = ins;
    FLUSH = fl;
    @(posedge CLK);
    #1;
    chk(tag, obs(), expect_of(ins, fl));
  endtask
  logic [31:0] dir [20] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3,
                            32'h002091B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020A1B3, 32'h022081B3,
                            32'h762081B3, 32'h0000A183, 32'h0030A023, 32'h00208063, 32'h008000EF,
                            32'h000080E7, 32'h123451B7, 32'h00001197, 32'h0000007F, 32'h4050D193};
  logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  initial begin
    INSTRUCTION = 32'h002081B3;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_hold", obs(), 19'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("reset_release_add", obs(), expect_of(32'h002081B3, 1'b0));
    for (int i = 0; i < 20; i++) step($sformatf("dir%0d_%h", i, dir[i]), dir[i], 1'b0);
    step("sub", 32'h402081B3, 1'b0);
    chk("sub_tc_alu", {13'h0, TWOSCOMP, ALUOP}, 19'b1_00000);
    step("jal", 32'h008000EF, 1'b0);
    chk("jal_fields", {13'h0, JUMP, JAL, MUX1, IMMEDIATE}, 19'b111_100);
    step("lui", 32'h123451B7, 1'b0);
    chk("lui_fields", {11'h0, ALUOP, IMMEDIATE}, 19'b01111_011);
    step("hold_pre", 32'h002081B3, 1'b0);
    INSTRUCTION = 32'h0000A183;
    #2;
    chk("hold_midcycle", obs(), expect_of(32'h002081B3, 1'b0));
    @(posedge CLK);
    #1;
    chk("hold_after_edge", obs(), expect_of(32'h0000A183, 1'b0));
    step("flush_lw", 32'h0000A183, 1'b1);
    step("after_flush_lw", 32'h0000A183, 1'b0);
    step("pre_async", 32'h008000EF, 1'b0);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_reset", obs(), 19'h0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [6:0] f7, opc;
      int r = $urandom_range(0, 3);
      f7 = r == 0 ? 7'h00 : r == 1 ? 7'h20 : r == 2 ? 7'h01 : 7'($urandom);
      r = $urandom_range(0, 10);
      opc = r < 9 ? opcs[r] : 7'($urandom);
      ins = {f7, 18'($urandom), opc};
      step($sformatf("rnd%0d_%h", i, ins), ins, $urandom_range(0, 9) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Registered main decoder for the RV32IM 5-stage pipeline; sits at the ID/EX boundary.
- Decodes the 32-bit INSTRUCTION from the IF/ID register into datapath control signals.
- Outputs are registered on CLK and feed the EX, MEM and WB stages.

Parameters:
- None.

Ports:
- CLK  input  1  pipeline clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset (0 = reset)
- FLUSH  input  1  synchronous bubble insert; loads all-zero controls
- INSTRUCTION  input  32  instruction word from IF/ID
- MUX1  output  1  ALU operand A select: 0 = rs1, 1 = PC
- MUX2  output  1  ALU operand B select: 0 = rs2, 1 = immediate
- MUX3  output  1  writeback select: 0 = ALU result, 1 = memory data
- REGISTERWRITE  output  1  register file write enable
- MEMORYWRITE  output  1  data memory store enable
- MEMORYREAD  output  1  data memory load enable
- BRANCH  output  1  conditional branch
- JUMP  output  1  unconditional jump (JAL or JALR); WB writes PC+4
- JAL  output  1  1 = JAL (PC-relative target), 0 = JALR when JUMP=1
- TWOSCOMP  output  1  negate operand B (subtract / compare)
- ALUOP  output  5  ALU operation code
- IMMEDIATE  output  3  immediate format: I=000, S=001, B=010, U=011, J=100

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0.
- Latency: exactly 1 cycle. Outputs reflect the INSTRUCTION sampled at the previous rising edge.
- FLUSH=1 at an edge: all outputs 0 next cycle (NOP). FLUSH has priority over decode; RESET has priority over FLUSH.
- Field definitions: opcode = INSTRUCTION[6:0], funct3 = INSTRUCTION[14:12], funct7 = INSTRUCTION[31:25].
- ALUOP encoding:
  - ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, OR 00110, AND 00111.
  - SRA 01101; FWD (pass B) 01111.
  - M-extension: 10 followed by funct3 (MUL 10000 … REMU 10111).
  - Branch compare: 11 followed by funct3.
- SUB uses ALUOP=ADD with TWOSCOMP=1.
- Per-opcode decode (any signal not listed is 0):
  - 0110011 R-type, REGISTERWRITE=1:
    - funct7=0000000: ALUOP = {00, funct3}.
    - funct7=0100000 with funct3=000: SUB (ALUOP=00000, TWOSCOMP=1).
    - funct7=0100000 with funct3=101: SRA (01101).
    - funct7=0000001: M-op {10, funct3}.
    - Any other funct7/funct3 combination: all zero (NOP).
  - 0010011 I-ALU: REGISTERWRITE=1, MUX2=1, IMM=I, ALUOP = {00, funct3}. funct3=101 with funct7=0100000 gives SRAI (01101). No SUB in this class.
  - 0000011 load: REGISTERWRITE=1, MEMORYREAD=1, MUX3=1, MUX2=1, IMM=I, ALUOP=ADD.
  - 0100011 store: MEMORYWRITE=1, MUX2=1, IMM=S, ALUOP=ADD.
  - 1100011 branch: BRANCH=1, TWOSCOMP=1, IMM=B, ALUOP = {11, funct3}.
  - 1101111 JAL: JUMP=1, JAL=1, REGISTERWRITE=1, MUX1=1, MUX2=1, IMM=J, ALUOP=ADD.
  - 1100111 JALR: JUMP=1, REGISTERWRITE=1, MUX2=1, IMM=I, ALUOP=ADD.
  - 0110111 LUI: REGISTERWRITE=1, MUX2=1, IMM=U, ALUOP=FWD.
  - 0010111 AUIPC: REGISTERWRITE=1, MUX1=1, MUX2=1, IMM=U, ALUOP=ADD.
  - Any other opcode: all zero.
- rd=x0 does not suppress REGISTERWRITE; the register file ignores x0 writes.

Optional Feature:
- Macro CU_ILLEGAL_DETECT_EN.
- Defined: adds output ILLEGAL (1 bit, registered, reset 0, cleared by FLUSH).
  - ILLEGAL=1 for any instruction that decodes to all-zero controls because of an unknown opcode or an illegal funct7/funct3 combination.
- Undefined: port absent; such instructions silently become NOP.

Test Plan:
- Reset: hold RESET=0 while applying add 0x002081B3 → all outputs 0. Release RESET, one edge → REGISTERWRITE=1, ALUOP=00000, MUX1=MUX2=MUX3=0, TWOSCOMP=0.
- R-type sweep:
  - sub 0x402081B3 → ALUOP=00000, TWOSCOMP=1.
  - and → 00111; or → 00110; xor → 00100; sll → 00001; srl → 00101; sra 0x4020D1B3 → 01101; slt → 00010.
  - mul 0x022081B3 → 10000.
  - funct7=0111011 (0x762081B3) → all zero; ILLEGAL=1 when CU_ILLEGAL_DETECT_EN is defined.
- Memory:
  - lw 0x0000A183 → MEMORYREAD=1, MUX3=1, MUX2=1, IMMEDIATE=000, REGISTERWRITE=1.
  - sw 0x0030A023 → MEMORYWRITE=1, IMMEDIATE=001, REGISTERWRITE=0.
- Control flow:
  - beq 0x00208063 → BRANCH=1, TWOSCOMP=1, ALUOP=11000, IMMEDIATE=010.
  - jal 0x008000EF → JUMP=1, JAL=1, MUX1=1, IMMEDIATE=100.
  - jalr 0x000080E7 → JUMP=1, JAL=0, MUX1=0.
- Upper immediates:
  - lui 0x123451B7 → ALUOP=01111, IMMEDIATE=011.
  - auipc 0x00001197 → MUX1=1, ALUOP=00000.
- Latency / flush / async reset:
  - Change INSTRUCTION mid-cycle → outputs unchanged until the next edge.
  - FLUSH=1 with lw → all zero next cycle.
  - RESET asserted mid-cycle → outputs go 0 immediately, without waiting for CLK.
